// File: rtl/irq_request_controller.sv
// Interrupt request front-end: edge-detects request lines into a pending register,
// masks them toward an external priority encoder and runs the req/ack/eoi handshake.
module irq_request_controller #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     irq_in,
    input  logic             mask_we,
    input  logic [N-1:0]     mask_in,
    output logic [N-1:0]     d,
    input  logic [IDX_W-1:0] enc,
    input  logic             vld,
    output logic             irq,
    output logic [IDX_W-1:0] irq_id,
    input  logic             ack,
    input  logic             eoi,
    output logic [N-1:0]     pending,
    output logic             in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     mask;
    logic [N-1:0]     prev;
    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     pending_nxt;
    logic             irq_nxt;
    logic [IDX_W-1:0] irq_id_nxt;
    logic             in_service_nxt;

    // Encoder sees only unmasked pending lines; masked lines keep latching.
    assign d    = pending & ~mask;
    assign rise = irq_in & ~prev;

    // Set wins over clear so a request arriving on its own ack edge is kept.
    assign pending_nxt = (pending & ~clr) | rise;

    always_comb begin
        state_nxt      = state;
        irq_nxt        = irq;
        irq_id_nxt     = irq_id;
        in_service_nxt = in_service;
        clr            = '0;
        case (state)
            IDLE: begin
                irq_nxt        = 1'b0;
                in_service_nxt = 1'b0;
                if (vld) begin
                    irq_id_nxt = enc;
                    irq_nxt    = 1'b1;
                    state_nxt  = REQ;
                end
            end
            // No preemption: the presented index stays frozen until acknowledged.
            REQ: begin
                if (ack) begin
                    clr[irq_id]    = 1'b1;
                    irq_nxt        = 1'b0;
                    in_service_nxt = 1'b1;
                    state_nxt      = SERVICE;
                end
            end
            SERVICE: begin
                irq_nxt = 1'b0;
                if (eoi) begin
                    in_service_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: begin
                irq_nxt        = 1'b0;
                in_service_nxt = 1'b0;
                state_nxt      = IDLE;
            end
        endcase
    end

    // prev resets to all ones so lines held high through reset do not fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            mask       <= '0;
            prev       <= '1;
            irq        <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            prev       <= irq_in;
            irq        <= irq_nxt;
            irq_id     <= irq_id_nxt;
            in_service <= in_service_nxt;
            if (mask_we) begin
                mask <= mask_in;
            end
        end
    end

endmodule

// File: tb/tb_irq_request_controller.sv
// Directed bench for irq_request_controller with a behavioural 4-input priority encoder.
module tb_irq_request_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_in;
    logic [3:0] d;
    logic [1:0] enc;
    logic       vld;
    logic       irq;
    logic [1:0] irq_id;
    logic       ack;
    logic       eoi;
    logic [3:0] pending;
    logic       in_service;

    int vectors;
    int miscompares;

    irq_request_controller #(.N(4), .IDX_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .d          (d),
        .enc        (enc),
        .vld        (vld),
        .irq        (irq),
        .irq_id     (irq_id),
        .ack        (ack),
        .eoi        (eoi),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set index wins.
    always_comb begin
        enc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (d[i]) enc = 2'(i);
        end
        vld = |d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_in = 4'b0110; mask_we = 1'b0; mask_in = 4'b0000; ack = 1'b0; eoi = 1'b0;
        step(); step();
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL rst_pending: got %b want %b", pending, 4'b0000); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq: got %b want %b", irq, 1'b0); end
        vectors++; if (irq_id !== 2'd0) begin miscompares++; $display("FAIL rst_irq_id: got %0d want %0d", irq_id, 0); end
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL rst_in_service: got %b want %b", in_service, 1'b0); end
        rst_n = 1'b1;
        step(); step(); step();
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL held_pending: got %b want %b", pending, 4'b0000); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL held_irq: got %b want %b", irq, 1'b0); end
        irq_in = 4'b0000;
        step();
    endtask

    task automatic test_single();
        irq_in = 4'b0010;
        step();
        vectors++; if (pending !== 4'b0010) begin miscompares++; $display("FAIL single_pend: got %b want %b", pending, 4'b0010); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL single_irq_k: got %b want %b", irq, 1'b0); end
        step();
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL single_irq_k1: got %b want %b", irq, 1'b1); end
        vectors++; if (irq_id !== 2'd1) begin miscompares++; $display("FAIL single_id: got %0d want %0d", irq_id, 1); end
        irq_in = 4'b0000; ack = 1'b1;
        step();
        ack = 1'b0;
        vectors++; if (pending !== 4'b0000) begin miscompares++; $display("FAIL single_ack_pend: got %b want %b", pending, 4'b0000); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL single_ack_irq: got %b want %b", irq, 1'b0); end
        vectors++; if (in_service !== 1'b1) begin miscompares++; $display("FAIL single_insvc: got %b want %b", in_service, 1'b1); end
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        vectors++; if (in_service !== 1'b0) begin miscompares++; $display("FAIL single_eoi: got %b want %b", in_service, 1'b0); end
        step();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL single_idle_irq: got %b want %b", irq, 1'b0); end
    endtask

    task automatic test_priority();
        irq_in = 4'b0101;
        step();
        vectors++; if (pending !== 4'b0101) begin miscompares++; $display("FAIL prio_pend: got %b want %b", pending, 4'b0101); end
        irq_in = 4'b0000;
        step();
        vectors++; if (irq_id !== 2'd2) begin miscompares++; $display("FAIL prio_first: got %0d want %0d", irq_id, 2); end
        ack = 1'b1; step(); ack = 1'b0;
        vectors++; if (pending !== 4'b0001) begin miscompares++; $display("FAIL prio_ack_pend: got %b want %b", pending, 4'b0001); end
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd0) begin miscompares++; $display("FAIL prio_second: got irq=%b id=%0d want irq=1 id=0", irq, irq_id); end
        irq_in = 4'b1000;
        step();
        vectors++; if (pending !== 4'b1001) begin miscompares++; $display("FAIL prio_late_pend: got %b want %b", pending, 4'b1001); end
        step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd0) begin miscompares++; $display("FAIL prio_nopreempt: got irq=%b id=%0d want irq=1 id=0", irq, irq_id); end
        irq_in = 4'b0000; ack = 1'b1; step(); ack = 1'b0;
        vectors++; if (pending !== 4'b1000) begin miscompares++; $display("FAIL prio_ack0_pend: got %b want %b", pending, 4'b1000); end
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd3) begin miscompares++; $display("FAIL prio_third: got irq=%b id=%0d want irq=1 id=3", irq, irq_id); end
        ack = 1'b1; step(); ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_in = 4'b1000; step(); mask_we = 1'b0;
        irq_in = 4'b1000;
        step();
        vectors++; if (pending !== 4'b1000) begin miscompares++; $display("FAIL mask_pend: got %b want %b", pending, 4'b1000); end
        vectors++; if (d !== 4'b0000) begin miscompares++; $display("FAIL mask_d: got %b want %b", d, 4'b0000); end
        step();
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mask_irq: got %b want %b", irq, 1'b0); end
        mask_we = 1'b1; mask_in = 4'b0000; step(); mask_we = 1'b0;
        vectors++; if (d !== 4'b1000) begin miscompares++; $display("FAIL unmask_d: got %b want %b", d, 4'b1000); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL unmask_irq_early: got %b want %b", irq, 1'b0); end
        step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd3) begin miscompares++; $display("FAIL unmask_irq: got irq=%b id=%0d want irq=1 id=3", irq, irq_id); end
        irq_in = 4'b0000; ack = 1'b1; step(); ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        irq_in = 4'b0010; step();
        irq_in = 4'b0000; step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd1) begin miscompares++; $display("FAIL b2b_req: got irq=%b id=%0d want irq=1 id=1", irq, irq_id); end
        irq_in = 4'b0010; ack = 1'b1;
        step();
        ack = 1'b0; irq_in = 4'b0000;
        vectors++; if (pending !== 4'b0010) begin miscompares++; $display("FAIL b2b_setwins: got %b want %b", pending, 4'b0010); end
        vectors++; if (in_service !== 1'b1) begin miscompares++; $display("FAIL b2b_insvc: got %b want %b", in_service, 1'b1); end
        eoi = 1'b1; step(); eoi = 1'b0;
        vectors++; if (irq !== 1'b0 || in_service !== 1'b0) begin miscompares++; $display("FAIL b2b_eoi: got irq=%b insvc=%b want irq=0 insvc=0", irq, in_service); end
        step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd1) begin miscompares++; $display("FAIL b2b_reassert: got irq=%b id=%0d want irq=1 id=1", irq, irq_id); end
        ack = 1'b1; step(); ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
    endtask

    task automatic test_stray_and_reset();
        ack = 1'b1;
        step();
        vectors++; if (irq !== 1'b0 || in_service !== 1'b0 || pending !== 4'b0000) begin miscompares++; $display("FAIL stray_ack_idle: got irq=%b insvc=%b pend=%b want 0 0 0000", irq, in_service, pending); end
        irq_in = 4'b0100;
        step();
        vectors++; if (pending !== 4'b0100 || irq !== 1'b0) begin miscompares++; $display("FAIL stray_ack_rise: got pend=%b irq=%b want 0100 0", pending, irq); end
        step();
        vectors++; if (irq !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b0100) begin miscompares++; $display("FAIL stray_ack_vld: got irq=%b id=%0d pend=%b want 1 2 0100", irq, irq_id, pending); end
        ack = 1'b0; eoi = 1'b1;
        step();
        vectors++; if (irq !== 1'b1 || in_service !== 1'b0 || pending !== 4'b0100) begin miscompares++; $display("FAIL stray_eoi_req: got irq=%b insvc=%b pend=%b want 1 0 0100", irq, in_service, pending); end
        ack = 1'b1; eoi = 1'b1;
        step();
        vectors++; if (in_service !== 1'b1 || irq !== 1'b0 || pending !== 4'b0000) begin miscompares++; $display("FAIL ack_eoi_req: got insvc=%b irq=%b pend=%b want 1 0 0000", in_service, irq, pending); end
        ack = 1'b0; eoi = 1'b0;
        step();
        vectors++; if (in_service !== 1'b1) begin miscompares++; $display("FAIL ack_eoi_hold: got %b want %b", in_service, 1'b1); end
        irq_in = 4'b0001; rst_n = 1'b0;
        step();
        vectors++; if (in_service !== 1'b0 || irq !== 1'b0 || irq_id !== 2'd0 || pending !== 4'b0000) begin miscompares++; $display("FAIL svc_reset: got insvc=%b irq=%b id=%0d pend=%b want 0 0 0 0000", in_service, irq, irq_id, pending); end
        rst_n = 1'b1;
        step(); step();
        vectors++; if (pending !== 4'b0000 || irq !== 1'b0) begin miscompares++; $display("FAIL post_reset: got pend=%b irq=%b want 0000 0", pending, irq); end
        irq_in = 4'b0000;
        step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_back_to_back();
        test_stray_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/irq_request_controller.md
Name: irq_request_controller

Overview:
- Interrupt request front-end sitting directly upstream of the team's 4-input priority encoder.
- Edge-detects and latches four request lines into a pending register, applies a mask and drives the encoder's D input.
- Consumes the encoder's ENC/VLD result and runs a request/acknowledge/end-of-interrupt handshake with the servicing logic.
- Priority is decided entirely by the encoder: the highest set index wins, so D[3] has the highest priority.

Parameters:
- N, 4, number of request lines; must match encoder D width.
- IDX_W, 2, index width, equal to clog2(N); must match encoder ENC width.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  reset, synchronous, active-low
- IRQ_IN  input  N  request lines, synchronous to CLK; rising edge = new request
- MASK_WE  input  1  mask write enable
- MASK_IN  input  N  mask write data; 1 = line masked
- D  output  N  PENDING & ~MASK, combinational, wired to encoder D
- ENC  input  IDX_W  encoder index (combinational from D)
- VLD  input  1  encoder valid (D != 0)
- IRQ  output  1  interrupt request to servicing logic
- IRQ_ID  output  IDX_W  index of the request being presented/serviced
- ACK  input  1  servicing logic accepts IRQ
- EOI  input  1  end of interrupt
- PENDING  output  N  raw pending register, status
- IN_SERVICE  output  1  high while in SERVICE state

Behaviour:
- Reset: when RST_N=0 at a rising edge, the following registers take these values:
  - PENDING=0, MASK=0, IRQ=0, IRQ_ID=0, state=IDLE, IN_SERVICE=0.
  - The previous-sample register takes all ones, so lines held high through reset do not fire.
  - Reset overrides every other input on that edge.
  - Reset mid-handshake drops every pending and in-flight request.
- Edge detect: rise[i] = IRQ_IN[i] & ~prev[i]. prev <= IRQ_IN every edge.
- Pending:
  - Each edge: PENDING <= (PENDING & ~clr) | rise.
  - clr is the one-hot of IRQ_ID when ACK is accepted, else 0.
  - Simultaneous rise and clr on the same bit: set wins, so the new request is kept.
  - A rise on an already-pending bit merges; no count is kept.
- Mask:
  - On MASK_WE, MASK <= MASK_IN at the edge.
  - Masked lines still latch into PENDING but are excluded from D.
  - Unmasking a pending line makes it visible on D the next cycle.
- FSM, 3 states:
  - IDLE: IRQ=0. If VLD=1 at the edge: IRQ_ID <= ENC, IRQ <= 1, go to REQ.
  - REQ: IRQ=1, IRQ_ID frozen. There is no preemption; higher-priority arrivals wait. Mask changes do not withdraw the request. If ACK=1: clear PENDING[IRQ_ID], IRQ <= 0, go to SERVICE.
  - SERVICE: IN_SERVICE=1, IRQ=0, IRQ_ID held. If EOI=1, go to IDLE.
  - ACK outside REQ and EOI outside SERVICE are ignored.
  - ACK and EOI asserted together in REQ: only ACK acts.
- Latency:
  - IRQ_IN high at edge k (prev low) -> PENDING bit set after edge k.
  - IRQ=1 after edge k+1.
  - ACK sampled at edge m -> IRQ=0 and bit cleared after edge m.
  - EOI at edge p -> IDLE after p. The next IRQ can assert after p+1 at the earliest.
- The encoder path is purely combinational; the block never registers ENC/VLD except into IRQ_ID.

Test Plan:
1. Reset with IRQ_IN=4'b0110 held, then release and hold IRQ_IN -> PENDING stays 0, IRQ stays 0.
2. Single rise on IRQ_IN[1] at edge k -> PENDING=4'b0010 after k; IRQ=1 and IRQ_ID=1 after k+1. ACK at m -> PENDING=0, IRQ=0, IN_SERVICE=1. EOI -> IN_SERVICE=0.
3. Rises on lines 0 and 2 at the same edge -> IRQ_ID=2 first. After ACK+EOI, IRQ_ID=0 is presented. Line 3 rising while line 0 is in REQ does not change IRQ_ID until line 0 completes.
4. MASK=4'b1000, then rise on line 3 -> PENDING[3]=1, D=0, IRQ=0. Write MASK=0 -> D=4'b1000 next cycle; IRQ=1 with IRQ_ID=3 one cycle later.
5. In REQ with IRQ_ID=1, line 1 rises again on the ACK edge -> after the edge PENDING[1]=1 (set wins) and state=SERVICE. After EOI, IRQ re-asserts with IRQ_ID=1.
6. Stray ACK in IDLE and stray EOI in REQ -> no state or PENDING change. Assert RST_N=0 during SERVICE -> all outputs return to their reset values on that edge.
